// File: rtl/count_uart_pkg.sv
// Shared types and constants for the count-value UART transmitter.
// Frame is 8N1: one start bit, DATA_BITS data bits LSB first, one stop bit.
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic TX_IDLE    = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while run is high, ticking on the last count.
// Latency: bit_tick is combinational from the divider register; clear restarts the phase next cycle.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign bit_tick = run && (div_q == TERM);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (run) begin
      div_d = (div_q == TERM) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Serialises the counter value as an 8N1 frame on request or on change; 10*CLKS_PER_BIT+1 cycles per frame.
// Requests are only accepted in IDLE (in_ready); nothing is queued while busy.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       auto_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       last_sent_q, last_sent_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             launch;
  logic             bit_tick;

  // Only evaluated in IDLE; an explicit request and a change in the same cycle give one frame.
  assign launch = (state_q == IDLE) &&
                  (in_valid || (auto_en && (cnt_in != last_sent_q)));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .run     (state_q != IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    last_sent_d = last_sent_q;
    bit_idx_d   = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d     = START;
          tx_d        = 1'b0;
          shift_d     = cnt_in;
          last_sent_d = cnt_in;
          bit_idx_d   = '0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d   = STOP;
            tx_d      = TX_IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[bit_idx_q + 1'b1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_q        <= TX_IDLE;
      shift_q     <= '0;
      last_sent_q <= '0;
      bit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      shift_q     <= shift_d;
      last_sent_q <= last_sent_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign tx         = tx_q;
  assign in_ready   = (state_q == IDLE);
  assign busy       = !in_ready;
  assign frame_done = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed plus random stimulus for count_uart_tx against a cycle-position frame model.
module tb_count_uart_tx;

  localparam int N  = 4;
  localparam int FL = 10 * N;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt_in;
  logic       in_valid;
  logic       auto_en;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .auto_en   (auto_en),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int fd_cnt = 0;
  logic txh [0:4095];

  // Model: a frame is just "position p within a 10N-cycle window" plus the latched byte.
  bit         m_busy = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic m_tx();
    int sym;
    if (!m_busy) return 1'b1;
    sym = (m_pos - 1) / N;
    if (sym == 0) return 1'b0;
    if (sym == 9) return 1'b1;
    return m_byte[sym-1];
  endfunction

  // Recovers the payload from the recorded line, sampling mid-bit, for a frame launched at t.
  function automatic logic [7:0] dec(input int t);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = txh[t + 1 + N*(k+1) + N/2];
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_last = 8'h00;
    end else if (!m_busy) begin
      if (in_valid || (auto_en && (cnt_in != m_last))) begin
        m_busy = 1'b1;
        m_pos  = 1;
        m_byte = cnt_in;
        m_last = cnt_in;
      end
    end else if (m_pos == FL) begin
      m_busy = 1'b0;
    end else begin
      m_pos++;
    end
    cyc_n++;
    #1;
    txh[cyc_n[11:0]] = tx;
    if (frame_done === 1'b1) fd_cnt++;
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_busy && (m_pos == FL)));
  endtask

  initial begin
    int t0;
    int fd0;
    logic [9:0] pat;

    rst = 1'b1; in_valid = 1'b0; auto_en = 1'b0; cnt_in = 8'h00;
    cyc(); cyc();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // idle with auto off
    fd0 = fd_cnt;
    repeat (20) cyc();
    chk("idle_no_frame_done", 32'(fd_cnt - fd0), 32'd0);

    // single explicit request for A5
    pat = {1'b1, 8'hA5, 1'b0};
    cnt_in = 8'hA5; in_valid = 1'b1; t0 = cyc_n; fd0 = fd_cnt;
    cyc();
    in_valid = 1'b0;
    repeat (40) cyc();
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < N; j++)
        chk("a5_symbol", 32'(txh[t0 + 1 + N*k + j]), 32'(pat[k]));
    chk("a5_frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    chk("a5_ready_at_t41", 32'(in_ready), 32'd1);

    // send-on-change: 00 never sent, 01 sent, intermediates dropped, 02 sent back-to-back
    rst = 1'b1; cyc(); rst = 1'b0;
    auto_en = 1'b1; cnt_in = 8'h00;
    repeat (5) cyc();
    chk("auto_00_no_frame", 32'(busy), 32'd0);
    cnt_in = 8'h01; t0 = cyc_n; fd0 = fd_cnt;
    cyc();
    for (int i = 0; i < 39; i++) begin
      cnt_in = 8'(8'h10 + i);
      cyc();
    end
    cnt_in = 8'h02;
    repeat (50) cyc();
    chk("auto_first_payload", 32'(dec(t0)), 32'h01);
    chk("auto_no_gap_idle", 32'(txh[t0 + 41]), 32'd1);
    chk("auto_no_gap_start", 32'(txh[t0 + 42]), 32'd0);
    chk("auto_second_payload", 32'(dec(t0 + 41)), 32'h02);
    chk("auto_frame_count", 32'(fd_cnt - fd0), 32'd2);
    auto_en = 1'b0;

    // in_valid held: frames every 41 cycles
    cnt_in = 8'h3C; in_valid = 1'b1; t0 = cyc_n; fd0 = fd_cnt;
    repeat (123) cyc();
    in_valid = 1'b0;
    chk("held_frame_count", 32'(fd_cnt - fd0), 32'd3);
    chk("held_payload0", 32'(dec(t0)), 32'h3C);
    chk("held_payload1", 32'(dec(t0 + 41)), 32'h3C);
    chk("held_payload2", 32'(dec(t0 + 82)), 32'h3C);
    repeat (5) cyc();

    // reset mid-DATA aborts, then auto relaunches 07 immediately
    cnt_in = 8'h55; in_valid = 1'b1; t0 = cyc_n; fd0 = fd_cnt;
    cyc();
    in_valid = 1'b0;
    repeat (16) cyc();
    rst = 1'b1; cnt_in = 8'h07; auto_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    cyc();
    chk("relaunch_start_bit", 32'(tx), 32'd0);
    repeat (40) cyc();
    chk("relaunch_payload", 32'(dec(t0 + 18)), 32'h07);
    chk("relaunch_frame_count", 32'(fd_cnt - fd0), 32'd1);
    auto_en = 1'b0;
    repeat (2) cyc();

    // request and change in the same cycle: exactly one frame
    cnt_in = 8'h99; auto_en = 1'b1; in_valid = 1'b1; t0 = cyc_n; fd0 = fd_cnt;
    cyc();
    in_valid = 1'b0;
    repeat (90) cyc();
    chk("both_single_frame", 32'(fd_cnt - fd0), 32'd1);
    chk("both_payload", 32'(dec(t0)), 32'h99);
    chk("both_idle_after", 32'(busy), 32'd0);
    auto_en = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 15) == 0) cnt_in = 8'($urandom);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
